// File: rtl/status_display_if.sv
// Status inputs and 7-segment display lines of the irrigation board.
// master drives status and reads the display; slave is the driver.
interface status_display_if;
  logic [2:0] water_level;
  logic [2:0] system_state;
  logic       alarm;
  logic       fertilising;
  logic       cleaning;
  logic [6:0] segments;
  logic [3:0] digit_n;
  logic       dp_n;

  modport master (
    output water_level,
    output system_state,
    output alarm,
    output fertilising,
    output cleaning,
    input  segments,
    input  digit_n,
    input  dp_n
  );

  modport slave (
    input  water_level,
    input  system_state,
    input  alarm,
    input  fertilising,
    input  cleaning,
    output segments,
    output digit_n,
    output dp_n
  );
endinterface

// File: rtl/status_display_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver.
// Shows tank fill %, a state letter, a cleaning flag and alarm blink.
module status_display_driver #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input logic            clock,
  input logic            reset,
  status_display_if.slave dif
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0] G_0     = 7'h40;
  localparam logic [6:0] G_1     = 7'h79;
  localparam logic [6:0] G_2     = 7'h24;
  localparam logic [6:0] G_3     = 7'h30;
  localparam logic [6:0] G_4     = 7'h19;
  localparam logic [6:0] G_5     = 7'h12;
  localparam logic [6:0] G_6     = 7'h02;
  localparam logic [6:0] G_7     = 7'h78;
  localparam logic [6:0] G_8     = 7'h00;
  localparam logic [6:0] G_9     = 7'h10;
  localparam logic [6:0] G_F     = 7'h0E;
  localparam logic [6:0] G_L     = 7'h47;
  localparam logic [6:0] G_C     = 7'h46;
  localparam logic [6:0] G_E     = 7'h06;
  localparam logic [6:0] G_S     = 7'h12;
  localparam logic [6:0] G_D     = 7'h21;
  localparam logic [6:0] G_DASH  = 7'h3F;
  localparam logic [6:0] G_BLANK = 7'h7F;

  // Letter for the system state code.
  function automatic logic [6:0] state_glyph(input logic [2:0] s);
    logic [6:0] g;
    unique case (s)
      3'd0:    g = G_DASH;
      3'd1:    g = G_F;
      3'd2:    g = G_C;
      3'd3:    g = G_E;
      3'd4:    g = G_S;
      3'd5:    g = G_D;
      default: g = G_E;
    endcase
    return g;
  endfunction

  // Tens digit of the fill percentage (level/7 * 100, "FL" when full).
  function automatic logic [6:0] tens_glyph(input logic [2:0] l);
    logic [6:0] g;
    unique case (l)
      3'd0:    g = G_0;
      3'd1:    g = G_1;
      3'd2:    g = G_2;
      3'd3:    g = G_4;
      3'd4:    g = G_5;
      3'd5:    g = G_7;
      3'd6:    g = G_8;
      default: g = G_F;
    endcase
    return g;
  endfunction

  // Units digit of the fill percentage.
  function automatic logic [6:0] units_glyph(input logic [2:0] l);
    logic [6:0] g;
    unique case (l)
      3'd0:    g = G_0;
      3'd1:    g = G_4;
      3'd2:    g = G_9;
      3'd3:    g = G_3;
      3'd4:    g = G_7;
      3'd5:    g = G_1;
      3'd6:    g = G_6;
      default: g = G_L;
    endcase
    return g;
  endfunction

  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    digit_q, digit_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          blink_q, blink_d;

  logic [2:0]    snap_lvl_q, snap_lvl_d;
  logic [2:0]    snap_st_q, snap_st_d;
  logic          snap_al_q, snap_al_d;
  logic          snap_fe_q, snap_fe_d;
  logic          snap_cl_q, snap_cl_d;

  logic [6:0]    seg_q, seg_d;
  logic [3:0]    digit_n_q, digit_n_d;
  logic          dp_n_q, dp_n_d;

  logic          slot_wrap;
  logic          frame_wrap;
  logic          snap_take;
  logic          lit;
  logic [6:0]    glyph;

  // Scan counters and the free-running blink divider.
  always_comb begin
    slot_wrap  = (slot_q == SW'(SCAN_DIV - 1));
    frame_wrap = slot_wrap && (digit_q == 2'd3);
    slot_d     = slot_wrap ? '0 : slot_q + 1'b1;
    digit_d    = slot_wrap ? digit_q + 2'd1 : digit_q;
    frame_d    = frame_q;
    blink_d    = blink_q;
    if (frame_wrap) begin
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  // Capture all inputs once per frame so a frame never tears.
  always_comb begin
    snap_take  = (slot_q == '0) && (digit_q == 2'd0);
    snap_lvl_d = snap_lvl_q;
    snap_st_d  = snap_st_q;
    snap_al_d  = snap_al_q;
    snap_fe_d  = snap_fe_q;
    snap_cl_d  = snap_cl_q;
    if (snap_take) begin
      snap_lvl_d = dif.water_level;
      snap_st_d  = dif.system_state;
      snap_al_d  = dif.alarm;
      snap_fe_d  = dif.fertilising;
      snap_cl_d  = dif.cleaning;
    end
  end

  // Select the glyph and enables for the digit the counters point at.
  always_comb begin
    lit = (slot_q >= SW'(BLANK_CYCLES)) && !(snap_al_q && blink_q);
    unique case (digit_q)
      2'd0:    glyph = units_glyph(snap_lvl_q);
      2'd1:    glyph = tens_glyph(snap_lvl_q);
      2'd2:    glyph = snap_cl_q ? G_C : G_BLANK;
      default: glyph = state_glyph(snap_st_q);
    endcase
    digit_n_d = 4'b1111;
    seg_d     = G_BLANK;
    dp_n_d    = 1'b1;
    if (lit) begin
      digit_n_d = ~(4'b0001 << digit_q);
      seg_d     = glyph;
      dp_n_d    = !((digit_q == 2'd3) && snap_fe_q);
    end
  end

  // State and registered outputs; reset goes straight to dark.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q     <= '0;
      digit_q    <= '0;
      frame_q    <= '0;
      blink_q    <= 1'b0;
      snap_lvl_q <= '0;
      snap_st_q  <= '0;
      snap_al_q  <= 1'b0;
      snap_fe_q  <= 1'b0;
      snap_cl_q  <= 1'b0;
      seg_q      <= G_BLANK;
      digit_n_q  <= 4'b1111;
      dp_n_q     <= 1'b1;
    end else begin
      slot_q     <= slot_d;
      digit_q    <= digit_d;
      frame_q    <= frame_d;
      blink_q    <= blink_d;
      snap_lvl_q <= snap_lvl_d;
      snap_st_q  <= snap_st_d;
      snap_al_q  <= snap_al_d;
      snap_fe_q  <= snap_fe_d;
      snap_cl_q  <= snap_cl_d;
      seg_q      <= seg_d;
      digit_n_q  <= digit_n_d;
      dp_n_q     <= dp_n_d;
    end
  end

  assign dif.segments = seg_q;
  assign dif.digit_n  = digit_n_q;
  assign dif.dp_n     = dp_n_q;

  a_one_digit: assert property (
    @(posedge clock) disable iff (reset)
    $countones(~digit_n_q) <= 1
  );

endmodule

// File: tb/tb_status_display_driver.sv
// Scoreboard bench for status_display_driver.
// A time-indexed model queues the expected output of every cycle.
module tb_status_display_driver;
  localparam int S  = 8;
  localparam int BL = 2;
  localparam int BF = 2;
  localparam int FR = 4 * S;

  logic clock = 1'b0;
  logic reset = 1'b1;

  status_display_if dif ();

  status_display_driver #(
    .SCAN_DIV    (S),
    .BLANK_CYCLES(BL),
    .BLINK_FRAMES(BF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dif  (dif.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] dn;
    logic       dp;
    int         frame;
    int         idx;
    bit         en;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   vectors = 0;
  int   miscompares = 0;

  int         m = 0;
  logic [2:0] s_lvl = '0;
  logic [2:0] s_st = '0;
  logic       s_al = 1'b0;
  logic       s_fe = 1'b0;
  logic       s_cl = 1'b0;

  function automatic logic [6:0] m_letter(input logic [2:0] s);
    case (s)
      3'd0: return 7'h3F;
      3'd1: return 7'h0E;
      3'd2: return 7'h46;
      3'd4: return 7'h12;
      3'd5: return 7'h21;
      default: return 7'h06;
    endcase
  endfunction

  function automatic logic [6:0] m_tens(input logic [2:0] l);
    case (l)
      3'd0: return 7'h40;
      3'd1: return 7'h79;
      3'd2: return 7'h24;
      3'd3: return 7'h19;
      3'd4: return 7'h12;
      3'd5: return 7'h78;
      3'd6: return 7'h00;
      default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [6:0] m_units(input logic [2:0] l);
    case (l)
      3'd0: return 7'h40;
      3'd1: return 7'h19;
      3'd2: return 7'h10;
      3'd3: return 7'h30;
      3'd4: return 7'h78;
      3'd5: return 7'h79;
      3'd6: return 7'h02;
      default: return 7'h47;
    endcase
  endfunction

  // Model: output after each edge is a function of cycles since reset.
  always @(posedge clock) begin : model
    exp_t e;
    int   slot;
    bit   ph;
    e.dn = 4'hF;
    e.seg = 7'h7F;
    e.dp = 1'b1;
    e.idx = 0;
    e.frame = -1;
    e.en = 1'b0;
    if (reset) begin
      m = 0;
      s_lvl = '0;
      s_st = '0;
      s_al = 1'b0;
      s_fe = 1'b0;
      s_cl = 1'b0;
    end else begin
      slot = m % S;
      e.idx = (m / S) % 4;
      e.frame = m / FR;
      ph = ((e.frame / BF) % 2) == 1;
      e.en = (slot >= BL) && !(s_al && ph);
      if (e.en) begin
        e.dn[e.idx] = 1'b0;
        case (e.idx)
          0: e.seg = m_units(s_lvl);
          1: e.seg = m_tens(s_lvl);
          2: e.seg = s_cl ? 7'h46 : 7'h7F;
          default: e.seg = m_letter(s_st);
        endcase
        e.dp = !(e.idx == 3 && s_fe);
      end
      if (m % FR == 0) begin
        s_lvl = dif.water_level;
        s_st = dif.system_state;
        s_al = dif.alarm;
        s_fe = dif.fertilising;
        s_cl = dif.cleaning;
      end
      m++;
    end
    sb.push_back(e);
  end

  task automatic test_reset();
    int first[4];
    reset = 1'b1;
    dif.water_level = 3'd0;
    dif.system_state = 3'd0;
    dif.alarm = 1'b0;
    dif.fertilising = 1'b0;
    dif.cleaning = 1'b0;
    repeat (3) begin
      @(negedge clock);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL rst_sb: queue empty");
      end else begin
        cur = sb.pop_front();
        if ({dif.digit_n, dif.segments, dif.dp_n} !== 12'b1111_1111111_1) begin
          miscompares++;
          $display("FAIL rst_idle: got %b/%h/%b want 1111/7f/1",
                   dif.digit_n, dif.segments, dif.dp_n);
        end
      end
    end
    reset = 1'b0;
    for (int d = 0; d < 4; d++) first[d] = -1;
    for (int c = 1; c <= FR; c++) begin
      @(negedge clock);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL scan_sb: queue empty");
      end else begin
        cur = sb.pop_front();
        if ({dif.digit_n, dif.segments, dif.dp_n} !== {cur.dn, cur.seg, cur.dp}) begin
          miscompares++;
          $display("FAIL scan_model: got %b/%h/%b want %b/%h/%b",
                   dif.digit_n, dif.segments, dif.dp_n, cur.dn, cur.seg, cur.dp);
        end
      end
      for (int d = 0; d < 4; d++)
        if (first[d] < 0 && dif.digit_n[d] === 1'b0) first[d] = c;
    end
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if (first[d] != 3 + S * d) begin
        miscompares++;
        $display("FAIL scan_start_d%0d: got cycle %0d want %0d", d, first[d], 3 + S * d);
      end
    end
  endtask

  task automatic test_level_decode();
    int         f0;
    int         guard;
    logic [6:0] want;
    for (int step = 0; step < 2; step++) begin
      dif.water_level = (step == 0) ? 3'd4 : 3'd7;
      dif.system_state = 3'd1;
      f0 = cur.frame + 1;
      guard = 0;
      while (cur.frame <= f0 && guard < 3 * FR) begin
        guard++;
        @(negedge clock);
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL lvl_sb: queue empty");
        end else begin
          cur = sb.pop_front();
          if ({dif.digit_n, dif.segments, dif.dp_n} !== {cur.dn, cur.seg, cur.dp}) begin
            miscompares++;
            $display("FAIL lvl_model: got %b/%h/%b want %b/%h/%b",
                     dif.digit_n, dif.segments, dif.dp_n, cur.dn, cur.seg, cur.dp);
          end
        end
        if (cur.frame == f0 && cur.en) begin
          case (cur.idx)
            0: want = (step == 0) ? 7'h78 : 7'h47;
            1: want = (step == 0) ? 7'h12 : 7'h0E;
            2: want = 7'h7F;
            default: want = 7'h0E;
          endcase
          vectors++;
          if (dif.segments !== want) begin
            miscompares++;
            $display("FAIL lvl%0d_digit%0d: got %h want %h", step, cur.idx, dif.segments, want);
          end
        end
      end
    end
  endtask

  task automatic test_snapshot();
    int         f0;
    int         g;
    int         guard;
    logic [6:0] want;
    dif.water_level = 3'd2;
    f0 = cur.frame + 1;
    g = -10;
    guard = 0;
    while (guard < 6 * FR && !(g >= 0 && cur.frame > g + 1)) begin
      guard++;
      @(negedge clock);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL snap_sb: queue empty");
      end else begin
        cur = sb.pop_front();
        if ({dif.digit_n, dif.segments, dif.dp_n} !== {cur.dn, cur.seg, cur.dp}) begin
          miscompares++;
          $display("FAIL snap_model: got %b/%h/%b want %b/%h/%b",
                   dif.digit_n, dif.segments, dif.dp_n, cur.dn, cur.seg, cur.dp);
        end
      end
      want = 7'h7F;
      if (cur.en && cur.frame >= f0 && (g < 0 || cur.frame == g) && cur.idx < 2)
        want = (cur.idx == 0) ? 7'h10 : 7'h24;
      if (cur.en && g >= 0 && cur.frame == g + 1 && cur.idx < 2)
        want = (cur.idx == 0) ? 7'h79 : 7'h78;
      if (want != 7'h7F) begin
        vectors++;
        if (dif.segments !== want) begin
          miscompares++;
          $display("FAIL snap_f%0d_d%0d: got %h want %h",
                   cur.frame, cur.idx, dif.segments, want);
        end
      end
      if (g < 0 && cur.frame >= f0 && cur.idx == 1 && cur.en) begin
        dif.water_level = 3'd5;
        g = cur.frame;
      end
    end
    vectors++;
    if (g < 0 || cur.frame <= g + 1) begin
      miscompares++;
      $display("FAIL snap_timeout: got frame %0d want > %0d", cur.frame, g + 1);
    end
  endtask

  task automatic test_status_flags();
    int   f0;
    int   guard;
    logic want_dp;
    dif.cleaning = 1'b1;
    dif.fertilising = 1'b1;
    f0 = cur.frame + 1;
    guard = 0;
    while (cur.frame <= f0 && guard < 3 * FR) begin
      guard++;
      @(negedge clock);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL flag_sb: queue empty");
      end else begin
        cur = sb.pop_front();
        if ({dif.digit_n, dif.segments, dif.dp_n} !== {cur.dn, cur.seg, cur.dp}) begin
          miscompares++;
          $display("FAIL flag_model: got %b/%h/%b want %b/%h/%b",
                   dif.digit_n, dif.segments, dif.dp_n, cur.dn, cur.seg, cur.dp);
        end
      end
      if (cur.frame == f0) begin
        want_dp = !(cur.en && cur.idx == 3);
        vectors++;
        if (dif.dp_n !== want_dp) begin
          miscompares++;
          $display("FAIL flag_dp_d%0d: got %b want %b", cur.idx, dif.dp_n, want_dp);
        end
        if (cur.en && cur.idx == 2) begin
          vectors++;
          if (dif.segments !== 7'h46) begin
            miscompares++;
            $display("FAIL flag_clean: got %h want 46", dif.segments);
          end
        end
      end
    end
    dif.cleaning = 1'b0;
    dif.fertilising = 1'b0;
  endtask

  task automatic test_alarm_blink();
    int f0;
    int guard;
    bit lit[4];
    bit want;
    for (int step = 0; step < 2; step++) begin
      dif.alarm = (step == 0);
      f0 = cur.frame + 1;
      for (int k = 0; k < 4; k++) lit[k] = 1'b0;
      guard = 0;
      while (cur.frame <= f0 + 3 && guard < 6 * FR) begin
        guard++;
        @(negedge clock);
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL blink_sb: queue empty");
        end else begin
          cur = sb.pop_front();
          if ({dif.digit_n, dif.segments, dif.dp_n} !== {cur.dn, cur.seg, cur.dp}) begin
            miscompares++;
            $display("FAIL blink_model: got %b/%h/%b want %b/%h/%b",
                     dif.digit_n, dif.segments, dif.dp_n, cur.dn, cur.seg, cur.dp);
          end
        end
        if (cur.frame >= f0 && cur.frame <= f0 + 3 && dif.digit_n !== 4'hF)
          lit[cur.frame - f0] = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        want = (step == 1) || ((((f0 + k) / BF) % 2) == 0);
        vectors++;
        if (lit[k] !== want) begin
          miscompares++;
          $display("FAIL blink%0d_frame%0d: lit %b want %b", step, f0 + k, lit[k], want);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int guard;
    int first_c;
    logic [3:0] first_dn;
    guard = 0;
    while (!(cur.idx == 2 && cur.en) && guard < 2 * FR) begin
      guard++;
      @(negedge clock);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL mid_sb: queue empty");
      end else begin
        cur = sb.pop_front();
        if ({dif.digit_n, dif.segments, dif.dp_n} !== {cur.dn, cur.seg, cur.dp}) begin
          miscompares++;
          $display("FAIL mid_model: got %b/%h/%b want %b/%h/%b",
                   dif.digit_n, dif.segments, dif.dp_n, cur.dn, cur.seg, cur.dp);
        end
      end
    end
    dif.water_level = 3'd3;
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if (sb.size() != 0) cur = sb.pop_front();
    if ({dif.digit_n, dif.segments, dif.dp_n} !== 12'b1111_1111111_1) begin
      miscompares++;
      $display("FAIL mid_reset_idle: got %b/%h/%b want 1111/7f/1",
               dif.digit_n, dif.segments, dif.dp_n);
    end
    reset = 1'b0;
    first_c = -1;
    first_dn = 4'hF;
    for (int c = 1; c <= 2 * FR; c++) begin
      @(negedge clock);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL restart_sb: queue empty");
      end else begin
        cur = sb.pop_front();
        if ({dif.digit_n, dif.segments, dif.dp_n} !== {cur.dn, cur.seg, cur.dp}) begin
          miscompares++;
          $display("FAIL restart_model: got %b/%h/%b want %b/%h/%b",
                   dif.digit_n, dif.segments, dif.dp_n, cur.dn, cur.seg, cur.dp);
        end
      end
      if (first_c < 0 && dif.digit_n !== 4'hF) begin
        first_c = c;
        first_dn = dif.digit_n;
      end
    end
    vectors++;
    if (first_c != 3 || first_dn !== 4'b1110) begin
      miscompares++;
      $display("FAIL restart_first: got cycle %0d digit_n %b want 3/1110", first_c, first_dn);
    end
  endtask

  initial begin
    cur.frame = -1;
    cur.idx = 0;
    cur.en = 1'b0;
    cur.dn = 4'hF;
    cur.seg = 7'h7F;
    cur.dp = 1'b1;
    test_reset();
    test_level_decode();
    test_snapshot();
    test_status_flags();
    test_alarm_blink();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
